// File: rtl/sevenseg_pkg.sv
// Shared constants for the multiplexed seven-segment driver: active-high segment
// patterns (bit 0 = a .. bit 6 = g), display modes and converter FSM encoding.
package sevenseg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b1111100;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic MODE_HEX = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'h0:    pattern = SEG_0;
            4'h1:    pattern = SEG_1;
            4'h2:    pattern = SEG_2;
            4'h3:    pattern = SEG_3;
            4'h4:    pattern = SEG_4;
            4'h5:    pattern = SEG_5;
            4'h6:    pattern = SEG_6;
            4'h7:    pattern = SEG_7;
            4'h8:    pattern = SEG_8;
            4'h9:    pattern = SEG_9;
            4'hA:    pattern = SEG_A;
            4'hB:    pattern = SEG_B;
            4'hC:    pattern = SEG_C;
            4'hD:    pattern = SEG_D;
            4'hE:    pattern = SEG_E;
            default: pattern = SEG_F;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one bit per cycle, DATA_W cycles per conversion.
// bcd/overflow carry the final result combinationally during the cycle done is high.
module bin2bcd_serial
    import sevenseg_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [0:0]          state;
    logic [DATA_W-1:0]   bin_sr;
    logic [4*DIGITS-1:0] bcd_sr;
    logic [4*DIGITS-1:0] bcd_adj;
    logic                ovf_sr;
    logic [CNT_W-1:0]    count;

    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
            end
        end
    end

    // A 1 leaving the top nibble means the value needs more digits than we have.
    assign bcd      = {bcd_adj[4*DIGITS-2:0], bin_sr[DATA_W-1]};
    assign overflow = ovf_sr | bcd_adj[4*DIGITS-1];
    assign busy     = (state == CONV);
    assign done     = (state == CONV) && (count == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            bin_sr <= '0;
            bcd_sr <= '0;
            ovf_sr <= 1'b0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr <= bin;
                        bcd_sr <= '0;
                        ovf_sr <= 1'b0;
                        count  <= '0;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    bin_sr <= bin_sr << 1;
                    bcd_sr <= bcd;
                    ovf_sr <= overflow;
                    count  <= count + CNT_W'(1);
                    if (done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed seven-segment driver with hex/decimal rendering and overflow dashes.
// Optional leading-zero blanking is enabled by defining SEVENSEG_LZB_EN.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int DATA_W         = 16,
    parameter int DIV_WIDTH      = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int EN_ACTIVE_LOW  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] value,
    input  logic              mode,
    input  logic              load,
    output logic              busy,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] en
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] EN_OFF  = (EN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic                       accept;
    logic                       conv_start;
    logic                       conv_busy;
    logic                       conv_done;
    logic [4*DIGITS-1:0]        conv_bcd;
    logic                       conv_ovf;
    logic [DATA_W+4*DIGITS-1:0] value_ext;
    logic [4*DIGITS-1:0]        hex_digits;
    logic                       hex_ovf;
    logic [4*DIGITS-1:0]        disp;
    logic                       disp_ovf;
    logic [DIV_WIDTH-1:0]       prescaler;
    logic [IDX_W-1:0]           idx;
    logic [IDX_W-1:0]           idx_next;
    logic                       active;
    logic                       active_next;
    logic [3:0]                 digit_val [DIGITS];
    logic [DIGITS-1:0]          blank;
    logic [6:0]                 seg_hi;
    logic [DIGITS-1:0]          en_hi;

    assign accept     = load & ~conv_busy;
    assign conv_start = accept & (mode == MODE_DEC);
    assign busy       = conv_busy;

    bin2bcd_serial #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk      (clk),
        .rst      (rst),
        .start    (conv_start),
        .bin      (value),
        .busy     (conv_busy),
        .done     (conv_done),
        .bcd      (conv_bcd),
        .overflow (conv_ovf)
    );

    // Zero-extend so narrow values fill the display and wide values expose their excess bits.
    assign value_ext  = {{(4*DIGITS){1'b0}}, value};
    assign hex_digits = value_ext[4*DIGITS-1:0];
    assign hex_ovf    = |(value_ext >> (4*DIGITS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp     <= '0;
            disp_ovf <= 1'b0;
        end else if (accept && (mode == MODE_HEX)) begin
            disp     <= hex_digits;
            disp_ovf <= hex_ovf;
        end else if (conv_done) begin
            disp     <= conv_bcd;
            disp_ovf <= conv_ovf;
        end
    end

    // The first prescaler wrap only switches the scan on; later wraps step the digit.
    always_comb begin
        idx_next    = idx;
        active_next = active;
        if (&prescaler) begin
            if (!active) begin
                active_next = 1'b1;
            end else if (idx == IDX_W'(DIGITS - 1)) begin
                idx_next = '0;
            end else begin
                idx_next = idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            idx       <= '0;
            active    <= 1'b0;
        end else begin
            prescaler <= prescaler + DIV_WIDTH'(1);
            idx       <= idx_next;
            active    <= active_next;
        end
    end

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            digit_val[i] = disp[4*i +: 4];
        end
    end

`ifdef SEVENSEG_LZB_EN
    logic upper_zero;

    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (digit_val[i] != 4'd0) begin
                upper_zero = 1'b0;
            end
            blank[i] = upper_zero;
        end
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        en_hi = '0;
        if (!active_next) begin
            seg_hi = SEG_BLANK;
        end else begin
            en_hi = DIGITS'(1) << idx_next;
            if (disp_ovf) begin
                seg_hi = SEG_DASH;
            end else if (blank[idx_next]) begin
                seg_hi = SEG_BLANK;
            end else begin
                seg_hi = hex_to_seg(digit_val[idx_next]);
            end
        end
    end

    // Enable and segment data share one register stage so they always switch together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_OFF;
            en  <= EN_OFF;
        end else begin
            seg <= seg_hi ^ SEG_OFF;
            en  <= en_hi ^ EN_OFF;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed self-checking bench for sevenseg_scan_driver (4 digits, 16-bit value, fast prescaler).
module tb_sevenseg_scan_driver;

    localparam logic [6:0] L_0    = 7'b1000000;
    localparam logic [6:0] L_1    = 7'b1111001;
    localparam logic [6:0] L_2    = 7'b0100100;
    localparam logic [6:0] L_3    = 7'b0110000;
    localparam logic [6:0] L_4    = 7'b0011001;
    localparam logic [6:0] L_7    = 7'b1111000;
    localparam logic [6:0] L_9    = 7'b0010000;
    localparam logic [6:0] L_B    = 7'b0000011;
    localparam logic [6:0] L_E    = 7'b0000110;
    localparam logic [6:0] L_F    = 7'b0001110;
    localparam logic [6:0] L_DASH = 7'b0111111;
    localparam logic [6:0] L_OFF  = 7'b1111111;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic        mode;
    logic        load;
    logic        busy;
    logic [6:0]  seg;
    logic [3:0]  en;

    int total;
    int bad;

    sevenseg_scan_driver #(
        .DIGITS         (4),
        .DATA_W         (16),
        .DIV_WIDTH      (2),
        .SEG_ACTIVE_LOW (1),
        .EN_ACTIVE_LOW  (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .mode  (mode),
        .load  (load),
        .busy  (busy),
        .seg   (seg),
        .en    (en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_value(input logic [15:0] v, input logic m);
        value = v;
        mode  = m;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    task automatic wait_digit(input int d, output bit ok);
        logic [3:0] want;
        want = ~(4'b0001 << d);
        ok   = 1'b0;
        tick();
        for (int k = 0; k < 64; k++) begin
            if (en === want) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic check_digits(input string name, input logic [6:0] e0, input logic [6:0] e1,
                                input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] exp_seg [4];
        bit ok;
        exp_seg[0] = e0;
        exp_seg[1] = e1;
        exp_seg[2] = e2;
        exp_seg[3] = e3;
        for (int d = 0; d < 4; d++) begin
            wait_digit(d, ok);
            total++;
            if (!ok || seg !== exp_seg[d]) begin
                bad++;
                $display("[TB] FAIL %s_digit%0d: seg=%b en=%b found=%0b, want seg=%b", name, d, seg, en, ok, exp_seg[d]);
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_en [4];
        exp_en[0] = 4'b1101;
        exp_en[1] = 4'b1011;
        exp_en[2] = 4'b0111;
        exp_en[3] = 4'b1110;
        rst = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0 || en !== 4'b1111 || seg !== L_OFF) begin
            bad++;
            $display("[TB] FAIL reset_state: busy=%b en=%b seg=%b, want 0 1111 %b", busy, en, seg, L_OFF);
        end
        rst = 1'b0;
        repeat (3) tick();
        total++;
        if (en !== 4'b1111 || seg !== L_OFF) begin
            bad++;
            $display("[TB] FAIL reset_before_wrap: en=%b seg=%b, want 1111 %b", en, seg, L_OFF);
        end
        tick();
        total++;
        if (en !== 4'b1110 || seg !== L_0) begin
            bad++;
            $display("[TB] FAIL reset_first_wrap: en=%b seg=%b, want 1110 %b", en, seg, L_0);
        end
        repeat (2) tick();
        total++;
        if (en !== 4'b1110) begin
            bad++;
            $display("[TB] FAIL reset_hold: en=%b, want 1110", en);
        end
        repeat (2) tick();
        for (int s = 0; s < 4; s++) begin
            if (s > 0) repeat (4) tick();
            total++;
            if (en !== exp_en[s] || seg !== L_0) begin
                bad++;
                $display("[TB] FAIL reset_scan%0d: en=%b seg=%b, want %b %b", s, en, seg, exp_en[s], L_0);
            end
        end
    endtask

    task automatic test_hex();
        load_value(16'hBEEF, 1'b0);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL hex_busy: busy=%b, want 0", busy);
        end
        check_digits("hex_beef", L_F, L_E, L_E, L_B);
    endtask

    task automatic test_decimal();
        logic [6:0] old_seg [4];
        int n;
        old_seg[0] = L_F;
        old_seg[1] = L_E;
        old_seg[2] = L_E;
        old_seg[3] = L_B;
        load_value(16'd1234, 1'b1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            for (int d = 0; d < 4; d++) begin
                if (en === ~(4'b0001 << d)) begin
                    total++;
                    if (seg !== old_seg[d]) begin
                        bad++;
                        $display("[TB] FAIL dec_hold_digit%0d: seg=%b, want %b", d, seg, old_seg[d]);
                    end
                end
            end
            tick();
        end
        total++;
        if (n !== 16) begin
            bad++;
            $display("[TB] FAIL dec_busy_len: cycles=%0d, want 16", n);
        end
        check_digits("dec_1234", L_4, L_3, L_2, L_1);
    endtask

    task automatic test_overflow();
        int n;
        load_value(16'd65535, 1'b1);
        wait_idle(n);
        total++;
        if (n !== 16) begin
            bad++;
            $display("[TB] FAIL ovf_busy_len: cycles=%0d, want 16", n);
        end
        check_digits("ovf_65535", L_DASH, L_DASH, L_DASH, L_DASH);
        load_value(16'h0009, 1'b0);
        check_digits("ovf_clear", L_9, L_0, L_0, L_0);
    endtask

    task automatic test_back_to_back();
        int n;
        load_value(16'd42, 1'b1);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_busy_rise: busy=%b, want 1", busy);
        end
        repeat (4) tick();
        load_value(16'd999, 1'b1);
        wait_idle(n);
        total++;
        if (n !== 11) begin
            bad++;
            $display("[TB] FAIL b2b_busy_rest: cycles=%0d, want 11", n);
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_no_queue: busy=%b, want 0", busy);
        end
        check_digits("b2b_42", L_2, L_4, L_0, L_0);

        load_value(16'd1234, 1'b1);
        repeat (7) tick();
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || en !== 4'b1111 || seg !== L_OFF) begin
            bad++;
            $display("[TB] FAIL abort_reset: busy=%b en=%b seg=%b, want 0 1111 %b", busy, en, seg, L_OFF);
        end
        tick();
        rst = 1'b0;
        check_digits("abort_zero", L_0, L_0, L_0, L_0);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_idle: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_leading_zeros();
        int n;
        load_value(16'd7, 1'b1);
        wait_idle(n);
`ifdef SEVENSEG_LZB_EN
        check_digits("lzb_7", L_7, L_OFF, L_OFF, L_OFF);
`else
        check_digits("lz_7", L_7, L_0, L_0, L_0);
`endif
        load_value(16'd0, 1'b1);
        wait_idle(n);
        total++;
        if (n !== 16) begin
            bad++;
            $display("[TB] FAIL lz_busy_len: cycles=%0d, want 16", n);
        end
`ifdef SEVENSEG_LZB_EN
        check_digits("lzb_0", L_0, L_OFF, L_OFF, L_OFF);
`else
        check_digits("lz_0", L_0, L_0, L_0, L_0);
`endif
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        value = '0;
        mode  = 1'b0;
        load  = 1'b0;
        $display("[TB] starting sevenseg_scan_driver bench");
        test_reset();
        test_hex();
        test_decimal();
        test_overflow();
        test_back_to_back();
        test_leading_zeros();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
Parametrised multiplexed seven-segment driver, successor to the fixed 4-digit/8-bit display mux used at the CPU top level. Accepts a DATA_W-bit value with a load handshake and renders it in hex or decimal. Decimal uses a serial double-dabble converter. Scans DIGITS common-anode digits at a prescaled refresh rate and shows an overflow indication when the value does not fit.

Parameters:
DIGITS, 4, number of scanned digits (1..8)
DATA_W, 16, input value width (1..32)
DIV_WIDTH, 16, refresh prescaler width; the digit advances every 2^DIV_WIDTH clk cycles
SEG_ACTIVE_LOW, 1, 1 = segment outputs active-low
EN_ACTIVE_LOW, 1, 1 = digit enables active-low

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
value  in  DATA_W  binary value to display
mode  in  1  0 = hex, 1 = unsigned decimal; sampled with load
load  in  1  capture request; accepted only when busy=0
busy  out  1  decimal conversion in progress
seg  out  7  segments, seg[0]=a .. seg[6]=g
en  out  DIGITS  one-hot digit enable (digit 0 = least significant)

Behaviour:
- Reset (async): busy=0; display digit registers=0; overflow flag=0; prescaler=0; digit index=0; seg=all inactive; en=all inactive. Reset mid-conversion aborts it, and the display returns to zeros.
- seg and en are registered outputs. Polarity is applied at the output flops only.
- Handshake: load is accepted when busy=0 and ignored when busy=1. There is no queueing.
- Hex path: on an accepted load, digit i = value[4i+3:4i], zero-extended where DATA_W<4*DIGITS. Display registers update on the next edge; busy stays 0. If any value bit at or above 4*DIGITS is set, overflow=1.
- Decimal path: FSM IDLE -> CONV -> IDLE.
  - Accepted load: the shift register is loaded and busy=1 on the next edge.
  - CONV runs exactly DATA_W cycles. Each cycle: add 3 to every BCD nibble >=5, then shift left 1.
  - Any 1 shifted out of the top BCD nibble sets a sticky overflow bit (value >= 10^DIGITS).
  - On the final CONV edge, the display registers and overflow update atomically and busy falls on that same edge.
- The display never shows partial conversion results.
- Overflow=1: all digits show a dash (segment g only).
- Scan:
  - The prescaler free-runs. On wrap (all-ones -> 0), the digit index advances 0..DIGITS-1 and wraps to 0.
  - Output flops load on every clk: en = onehot(index) and seg = encode(display[index]). Enable and segment data always change together, with no ghosting.
  - The first active enable appears at the first prescaler wrap after reset. Until then, outputs stay inactive.
- A display update is visible on seg at most 1 cycle after the display registers change, and only while that digit is selected.
- DIGITS=1: the index stays 0 and en is a constant one-hot once active.

Optional Feature:
SEVENSEG_LZB_EN: leading-zero blanking.
- Defined: digits above the most significant nonzero digit show blank (all segments inactive). Digit 0 always shows, so a value of 0 displays "0". Overflow dashes are unaffected.
- Undefined: all digits show, including leading zeros.

Decomposition:
- Package sevenseg_pkg:
  - 7-bit active-high segment constants for 0-F, DASH (7'b1000000) and BLANK (7'b0000000).
  - Mode constants MODE_HEX=0 and MODE_DEC=1.
  - FSM state encoding IDLE/CONV.
- One sub-module, bin2bcd_serial: start/busy/done handshake, DATA_W in, DIGITS*4 BCD out plus an overflow bit.
- Scan and encode logic stay in the parent.

Test Plan:
All scenarios use DIGITS=4, DATA_W=16, DIV_WIDTH=2, both polarity parameters =1.
1. Reset, no load -> en steps 1110, 1101, 1011, 0111, 1110 every 4 cycles; seg=7'b1000000 ("0") on every digit.
2. Hex load 0xBEEF -> busy stays 0; digits 0..3 show F,E,E,B (seg 0001110, 0000110, 0000110, 0000011).
3. Decimal load 1234 -> busy high for exactly 16 cycles; afterwards digits 0..3 show 4,3,2,1; the display is unchanged while busy.
4. Decimal load 65535 -> overflow; all digits show 7'b0111111 (dash). Then hex load 0x0009 -> overflow clears; digits show 9,0,0,0.
5. Load 42 (decimal); pulse load with 999 at cycle 5 of busy -> 999 ignored, 42 displayed. Assert rst at cycle 8 of a new conversion -> busy=0 immediately; display is zeros.
6. With SEVENSEG_LZB_EN: decimal 7 -> digit 0 shows "7" and digits 1..3 show 7'b1111111. Decimal 0 -> only digit 0 is lit and shows "0".
